// File: rtl/lcd_text_pkg.sv
// Shared constants, types and helpers for the LCD text buffer.
package lcd_text_pkg;

  localparam int unsigned LCD_CHARS      = 32;
  localparam int unsigned CHAR_W         = 8;
  localparam int unsigned POS_W          = 5;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned CHARS_PER_WORD = 4;
  localparam int unsigned NUM_WORDS      = 8;
  localparam int unsigned LINE2_BASE     = 16;

  localparam logic [7:0] CMD_CLEAR     = 8'h00;
  localparam logic [7:0] CMD_HOME      = 8'h01;
  localparam logic [7:0] CMD_LINE2     = 8'h02;
  localparam logic [7:0] CMD_COMMIT    = 8'h03;
  localparam logic [7:0] CMD_GOTO_BASE = 8'h20;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef logic [LCD_CHARS-1:0][CHAR_W-1:0] text_buf_t;

  // Pack four consecutive positions of a buffer into one word, lowest position in the MS byte.
  function automatic logic [WORD_W-1:0] pack_word(input text_buf_t b, input int unsigned w);
    int unsigned base;
    base = w * CHARS_PER_WORD;
    return {b[POS_W'(base)], b[POS_W'(base + 1)], b[POS_W'(base + 2)], b[POS_W'(base + 3)]};
  endfunction

  // GOTO occupies codes 8'h20..8'h3F; the low five bits are the target position.
  function automatic logic is_goto(input logic [7:0] code);
    return (code[7:5] == CMD_GOTO_BASE[7:5]);
  endfunction

endpackage

// File: rtl/lcd_text_shadow.sv
// Committed 32-byte shadow copy feeding the LCD controller text words.
module lcd_text_shadow
  import lcd_text_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              lcdclk,
  input  logic              resetn,
  input  logic              i_load,
  input  text_buf_t         i_load_data,
  input  logic              i_wr_en,
  input  logic [POS_W-1:0]  i_wr_pos,
  input  logic [7:0]        i_wr_data,
  output logic [WORD_W-1:0] o_reg_a,
  output logic [WORD_W-1:0] o_reg_b,
  output logic [WORD_W-1:0] o_reg_c,
  output logic [WORD_W-1:0] o_reg_d,
  output logic [WORD_W-1:0] o_reg_e,
  output logic [WORD_W-1:0] o_reg_f,
  output logic [WORD_W-1:0] o_reg_g,
  output logic [WORD_W-1:0] o_reg_h
);

  text_buf_t r_shadow;

  // Whole-frame load on commit; single-byte write when mirroring working-buffer writes.
  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      r_shadow <= {LCD_CHARS{BLANK_CHAR}};
    end else if (i_load) begin
      r_shadow <= i_load_data;
    end else if (i_wr_en) begin
      r_shadow[i_wr_pos] <= i_wr_data;
    end
  end

  assign o_reg_a = pack_word(r_shadow, 0);
  assign o_reg_b = pack_word(r_shadow, 1);
  assign o_reg_c = pack_word(r_shadow, 2);
  assign o_reg_d = pack_word(r_shadow, 3);
  assign o_reg_e = pack_word(r_shadow, 4);
  assign o_reg_f = pack_word(r_shadow, 5);
  assign o_reg_g = pack_word(r_shadow, 6);
  assign o_reg_h = pack_word(r_shadow, 7);

endmodule

// File: rtl/lcd_text_buffer.sv
// Byte-stream text buffer with cursor, clear sequencer and double-buffered output.
module lcd_text_buffer
  import lcd_text_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR  = 8'h20,
  parameter bit         AUTO_COMMIT = 1'b0
) (
  input  logic        lcdclk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic        in_is_cmd,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] reg_a,
  output logic [31:0] reg_b,
  output logic [31:0] reg_c,
  output logic [31:0] reg_d,
  output logic [31:0] reg_e,
  output logic [31:0] reg_f,
  output logic [31:0] reg_g,
  output logic [31:0] reg_h,
  output logic [4:0]  cursor,
  output logic        busy,
  output logic [7:0]  commit_cnt
);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [POS_W-1:0] r_cursor;
  logic [POS_W-1:0] w_cursor_nxt;
  logic [POS_W-1:0] r_clr_idx;
  logic [POS_W-1:0] w_clr_idx_nxt;
  logic             r_in_ready;
  logic             r_busy;
  logic [7:0]       r_commit_cnt;
  text_buf_t        r_buf;

  logic             w_xfer;
  logic             w_wr_en;
  logic [POS_W-1:0] w_wr_pos;
  logic [7:0]       w_wr_data;
  logic             w_commit;

  assign w_xfer = in_valid & r_in_ready;

  // State, cursor, clear index, handshake flags and commit counter.
  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_cursor     <= '0;
      r_clr_idx    <= '0;
      r_commit_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == ST_IDLE);
      r_busy     <= (w_state_nxt == ST_CLEAR);
      r_cursor   <= w_cursor_nxt;
      r_clr_idx  <= w_clr_idx_nxt;
      if (w_commit) begin
        r_commit_cnt <= r_commit_cnt + 8'd1;
      end
    end
  end

  // Working buffer: one byte written per cycle, either a character or a clear blank.
  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      r_buf <= {LCD_CHARS{BLANK_CHAR}};
    end else if (w_wr_en) begin
      r_buf[w_wr_pos] <= w_wr_data;
    end
  end

  // Next-state, cursor movement, command decode and buffer write control.
  always_comb begin
    w_state_nxt   = r_state;
    w_cursor_nxt  = r_cursor;
    w_clr_idx_nxt = r_clr_idx;
    w_wr_en       = 1'b0;
    w_wr_pos      = r_cursor;
    w_wr_data     = in_data;
    w_commit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (!in_is_cmd) begin
            w_wr_en      = 1'b1;
            w_cursor_nxt = r_cursor + POS_W'(1);
          end else begin
            case (in_data)
              CMD_CLEAR: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_idx_nxt = '0;
              end
              CMD_HOME:   w_cursor_nxt = '0;
              CMD_LINE2:  w_cursor_nxt = POS_W'(LINE2_BASE);
              CMD_COMMIT: w_commit     = 1'b1;
              default: begin
                if (is_goto(in_data)) begin
                  w_cursor_nxt = in_data[POS_W-1:0];
                end
              end
            endcase
          end
        end
      end
      ST_CLEAR: begin
        w_wr_en       = 1'b1;
        w_wr_pos      = r_clr_idx;
        w_wr_data     = BLANK_CHAR;
        w_clr_idx_nxt = r_clr_idx + POS_W'(1);
        if (r_clr_idx == POS_W'(LCD_CHARS - 1)) begin
          w_state_nxt  = ST_IDLE;
          w_cursor_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  lcd_text_shadow #(
    .BLANK_CHAR (BLANK_CHAR)
  ) u_shadow (
    .lcdclk      (lcdclk),
    .resetn      (resetn),
    .i_load      (w_commit),
    .i_load_data (r_buf),
    .i_wr_en     (AUTO_COMMIT & w_wr_en),
    .i_wr_pos    (w_wr_pos),
    .i_wr_data   (w_wr_data),
    .o_reg_a     (reg_a),
    .o_reg_b     (reg_b),
    .o_reg_c     (reg_c),
    .o_reg_d     (reg_d),
    .o_reg_e     (reg_e),
    .o_reg_f     (reg_f),
    .o_reg_g     (reg_g),
    .o_reg_h     (reg_h)
  );

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign cursor     = r_cursor;
  assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: one explicit-commit and one auto-commit instance on a shared stream.
module tb_lcd_text_buffer;

  logic        lcdclk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_is_cmd;
  logic [7:0]  in_data;

  logic        nrdy, ardy, nbusy, abusy;
  logic [4:0]  ncur, acur;
  logic [7:0]  ncnt, acnt;
  logic [31:0] nreg [8];
  logic [31:0] areg [8];

  int errors = 0;
  int checks = 0;

  // Reference model: working text, explicit-commit shadow, auto-commit shadow.
  logic [7:0] mw  [32];
  logic [7:0] ms  [32];
  logic [7:0] msa [32];
  int         mcur;
  int         mcnt;

  always #5 lcdclk = ~lcdclk;

  lcd_text_buffer #(.BLANK_CHAR(8'h20), .AUTO_COMMIT(1'b0)) dut (
    .lcdclk(lcdclk), .resetn(resetn), .in_valid(in_valid), .in_is_cmd(in_is_cmd),
    .in_data(in_data), .in_ready(nrdy),
    .reg_a(nreg[0]), .reg_b(nreg[1]), .reg_c(nreg[2]), .reg_d(nreg[3]),
    .reg_e(nreg[4]), .reg_f(nreg[5]), .reg_g(nreg[6]), .reg_h(nreg[7]),
    .cursor(ncur), .busy(nbusy), .commit_cnt(ncnt)
  );

  lcd_text_buffer #(.BLANK_CHAR(8'h20), .AUTO_COMMIT(1'b1)) dut_auto (
    .lcdclk(lcdclk), .resetn(resetn), .in_valid(in_valid), .in_is_cmd(in_is_cmd),
    .in_data(in_data), .in_ready(ardy),
    .reg_a(areg[0]), .reg_b(areg[1]), .reg_c(areg[2]), .reg_d(areg[3]),
    .reg_e(areg[4]), .reg_f(areg[5]), .reg_g(areg[6]), .reg_h(areg[7]),
    .cursor(acur), .busy(abusy), .commit_cnt(acnt)
  );

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mw[i] = 8'h20; ms[i] = 8'h20; msa[i] = 8'h20;
    end
    mcur = 0;
    mcnt = 0;
  endfunction

  // Effect of one accepted byte; a clear is modelled by its final result.
  function automatic void model_xfer(input bit cmd, input logic [7:0] d);
    if (!cmd) begin
      mw[mcur]  = d;
      msa[mcur] = d;
      mcur = (mcur + 1) % 32;
    end else if (d == 8'h00) begin
      for (int i = 0; i < 32; i++) begin mw[i] = 8'h20; msa[i] = 8'h20; end
      mcur = 0;
    end else if (d == 8'h01) mcur = 0;
    else if (d == 8'h02) mcur = 16;
    else if (d == 8'h03) begin
      for (int i = 0; i < 32; i++) begin ms[i] = mw[i]; msa[i] = mw[i]; end
      mcnt = (mcnt + 1) % 256;
    end else if (d >= 8'h20 && d <= 8'h3F) mcur = int'(d) - 32;
  endfunction

  function automatic logic [31:0] model_word(input bit auto_sel, input int w);
    if (auto_sel) return {msa[4*w], msa[4*w+1], msa[4*w+2], msa[4*w+3]};
    return {ms[4*w], ms[4*w+1], ms[4*w+2], ms[4*w+3]};
  endfunction

  // Offer one byte (called at a falling edge), wait for ready, update model on the transfer edge.
  task automatic send(input bit cmd, input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1; in_is_cmd = cmd; in_data = d;
    while (nrdy !== 1'b1 && n < 100) begin
      @(negedge lcdclk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", nrdy, n);
      in_valid = 1'b0;
    end else begin
      @(posedge lcdclk);
      model_xfer(cmd, d);
      @(negedge lcdclk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (nrdy !== 1'b1 && n < 100) begin
      @(negedge lcdclk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_ready_timeout: in_ready=%b, required 1", tag, nrdy);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_is_cmd = 1'b0; in_data = 8'h00;
    resetn = 1'b0;
    repeat (3) @(negedge lcdclk);
    resetn = 1'b1;
    model_reset();
    @(negedge lcdclk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (nreg[w] !== 32'h20202020) begin errors++; $display("FAIL reset_nreg%0d got %h exp 20202020", w, nreg[w]); end
      checks++;
      if (areg[w] !== 32'h20202020) begin errors++; $display("FAIL reset_areg%0d got %h exp 20202020", w, areg[w]); end
    end
    checks++;
    if ({ncur, nrdy, nbusy, ncnt} !== {5'd0, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL reset_ctrl cur=%0d rdy=%b busy=%b cnt=%0d exp 0/1/0/0", ncur, nrdy, nbusy, ncnt);
    end
    checks++;
    if ({acur, ardy, abusy, acnt} !== {5'd0, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL reset_ctrl_auto cur=%0d rdy=%b busy=%b cnt=%0d exp 0/1/0/0", acur, ardy, abusy, acnt);
    end
  endtask

  task automatic test_text();
    string s = "Text-LCD";
    for (int i = 0; i < s.len(); i++) send(1'b0, s[i]);
    checks++;
    if (nreg[0] !== 32'h20202020) begin errors++; $display("FAIL text_precommit reg_a got %h exp 20202020", nreg[0]); end
    checks++;
    if (areg[0] !== 32'h54657874) begin errors++; $display("FAIL text_auto_precommit reg_a got %h exp 54657874", areg[0]); end
    send(1'b1, 8'h03);
    checks++;
    if (nreg[0] !== 32'h54657874) begin errors++; $display("FAIL text_reg_a got %h exp 54657874", nreg[0]); end
    checks++;
    if (nreg[1] !== 32'h2D4C4344) begin errors++; $display("FAIL text_reg_b got %h exp 2D4C4344", nreg[1]); end
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (nreg[w] !== model_word(1'b0, w)) begin errors++; $display("FAIL text_nreg%0d got %h exp %h", w, nreg[w], model_word(1'b0, w)); end
    end
    checks++;
    if (ncur !== 5'd8 || ncnt !== 8'd1) begin errors++; $display("FAIL text_ctrl cur=%0d cnt=%0d exp 8/1", ncur, ncnt); end
  endtask

  task automatic test_line2_wrap();
    send(1'b1, 8'h02);
    send(1'b0, "S"); send(1'b0, "o"); send(1'b0, "C");
    send(1'b1, 8'h03);
    checks++;
    if (nreg[4] !== 32'h536F4320) begin errors++; $display("FAIL line2_reg_e got %h exp 536F4320", nreg[4]); end
    checks++;
    if (ncur !== 5'd19) begin errors++; $display("FAIL line2_cursor got %0d exp 19", ncur); end
    send(1'b1, 8'h3F);
    send(1'b0, "A"); send(1'b0, "B");
    checks++;
    if (ncur !== 5'd1) begin errors++; $display("FAIL wrap_cursor got %0d exp 1", ncur); end
    send(1'b1, 8'h03);
    checks++;
    if (nreg[7][7:0] !== 8'h41 || nreg[0][31:24] !== 8'h42) begin
      errors++; $display("FAIL wrap_bytes pos31=%h pos0=%h exp 41/42", nreg[7][7:0], nreg[0][31:24]);
    end
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (areg[w] !== model_word(1'b1, w)) begin errors++; $display("FAIL wrap_areg%0d got %h exp %h", w, areg[w], model_word(1'b1, w)); end
    end
  endtask

  task automatic test_clear();
    int low = 0;
    int busy_bad = 0;
    for (int i = 0; i < 32; i++) send(1'b0, "X");
    send(1'b1, 8'h00);
    in_valid = 1'b1; in_is_cmd = 1'b0; in_data = "Y";
    while (nrdy !== 1'b1 && low < 100) begin
      if (nbusy !== 1'b1 || abusy !== 1'b1 || ardy !== 1'b0) busy_bad++;
      low++;
      @(negedge lcdclk);
    end
    checks++;
    if (low != 32) begin errors++; $display("FAIL clear_ready_low got %0d cycles exp 32", low); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL clear_busy got %0d bad cycles exp 0", busy_bad); end
    @(posedge lcdclk);
    model_xfer(1'b0, "Y");
    @(negedge lcdclk);
    in_valid = 1'b0;
    send(1'b1, 8'h03);
    checks++;
    if (nreg[0] !== 32'h59202020) begin errors++; $display("FAIL clear_reg_a got %h exp 59202020", nreg[0]); end
    checks++;
    if (ncur !== 5'd1 || nbusy !== 1'b0) begin errors++; $display("FAIL clear_ctrl cur=%0d busy=%b exp 1/0", ncur, nbusy); end
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (nreg[w] !== model_word(1'b0, w)) begin errors++; $display("FAIL clear_nreg%0d got %h exp %h", w, nreg[w], model_word(1'b0, w)); end
      checks++;
      if (areg[w] !== model_word(1'b1, w)) begin errors++; $display("FAIL clear_areg%0d got %h exp %h", w, areg[w], model_word(1'b1, w)); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_seen = 0;
    send(1'b1, 8'h00);
    repeat (10) @(negedge lcdclk);
    resetn = 1'b0;
    #1;
    model_reset();
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (nreg[w] !== 32'h20202020 || areg[w] !== 32'h20202020) begin
        errors++; $display("FAIL midclr_reg%0d got %h/%h exp 20202020", w, nreg[w], areg[w]);
      end
    end
    checks++;
    if ({ncur, nrdy, nbusy, ncnt} !== {5'd0, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL midclr_ctrl cur=%0d rdy=%b busy=%b cnt=%0d exp 0/1/0/0", ncur, nrdy, nbusy, ncnt);
    end
    @(negedge lcdclk);
    resetn = 1'b1;
    repeat (5) begin
      @(negedge lcdclk);
      if (nbusy !== 1'b0 || nrdy !== 1'b1) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin errors++; $display("FAIL midclr_resumed got %0d busy cycles exp 0", busy_seen); end
  endtask

  task automatic test_auto();
    send(1'b1, 8'h25);
    send(1'b0, "Z");
    checks++;
    if (areg[1][23:16] !== 8'h5A) begin errors++; $display("FAIL auto_byte got %h exp 5A", areg[1][23:16]); end
    checks++;
    if (nreg[1] !== 32'h20202020) begin errors++; $display("FAIL auto_nonauto_reg_b got %h exp 20202020", nreg[1]); end
    checks++;
    if (acnt !== 8'd0 || acur !== 5'd6) begin errors++; $display("FAIL auto_ctrl cnt=%0d cur=%0d exp 0/6", acnt, acur); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      int r = $urandom_range(0, 99);
      logic [7:0] d;
      if (r < 55) send(1'b0, 8'($urandom_range(0, 255)));
      else if (r < 65) send(1'b1, 8'h03);
      else if (r < 72) send(1'b1, 8'h01);
      else if (r < 79) send(1'b1, 8'h02);
      else if (r < 90) send(1'b1, 8'(8'h20 + $urandom_range(0, 31)));
      else if (r < 97) begin
        d = 8'($urandom_range(4, 255));
        if (d >= 8'h20 && d <= 8'h3F) d = d + 8'h20;
        send(1'b1, d);
      end else begin
        send(1'b1, 8'h00);
        wait_ready("rand_clear");
      end
      checks++;
      if (ncur !== 5'(mcur) || acur !== 5'(mcur)) begin
        errors++; $display("FAIL rand%0d_cursor got %0d/%0d exp %0d", k, ncur, acur, mcur);
      end
      checks++;
      if (ncnt !== 8'(mcnt) || acnt !== 8'(mcnt)) begin
        errors++; $display("FAIL rand%0d_cnt got %0d/%0d exp %0d", k, ncnt, acnt, mcnt);
      end
      for (int w = 0; w < 8; w++) begin
        checks++;
        if (nreg[w] !== model_word(1'b0, w) || areg[w] !== model_word(1'b1, w)) begin
          errors++; $display("FAIL rand%0d_word%0d got %h/%h exp %h/%h", k, w, nreg[w], areg[w],
                             model_word(1'b0, w), model_word(1'b1, w));
        end
      end
    end
  endtask

  task automatic test_commit_wrap();
    do_reset();
    repeat (255) send(1'b1, 8'h03);
    checks++;
    if (ncnt !== 8'd255 || acnt !== 8'd255) begin errors++; $display("FAIL wrap255_cnt got %0d/%0d exp 255", ncnt, acnt); end
    send(1'b1, 8'h03);
    checks++;
    if (ncnt !== 8'd0 || acnt !== 8'd0) begin errors++; $display("FAIL wrap0_cnt got %0d/%0d exp 0", ncnt, acnt); end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_is_cmd = 1'b0; in_data = 8'h00;
    test_reset();
    test_text();
    test_line2_wrap();
    test_clear();
    test_reset_mid_clear();
    test_auto();
    test_random();
    test_commit_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
